// File: rtl/l1_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// l1_mem_port_arbiter : round-robin burst arbiter sharing one memory port
//                       between the L1 instruction fill and L1 data fill.
// Revision: 1.0
// ============================================================================
module l1_mem_port_arbiter #(
   parameter int P_BURST_BEATS = 8,
   parameter int P_CNT_W       = 4
) (
   input  logic        iCLOCK,
   input  logic        inRESET,
   input  logic        iREMOVE,
   input  logic        iR0_REQ,
   output logic        oR0_LOCK,
   input  logic [3:0]  iR0_BEATS,
   input  logic [1:0]  iR0_ORDER,
   input  logic        iR0_RW,
   input  logic [31:0] iR0_ADDR,
   input  logic [31:0] iR0_DATA,
   output logic        oR0_VALID,
   output logic        oR0_PAGEFAULT,
   output logic [63:0] oR0_DATA,
   input  logic        iR1_REQ,
   output logic        oR1_LOCK,
   input  logic [3:0]  iR1_BEATS,
   input  logic [1:0]  iR1_ORDER,
   input  logic        iR1_RW,
   input  logic [31:0] iR1_ADDR,
   input  logic [31:0] iR1_DATA,
   output logic        oR1_VALID,
   output logic        oR1_PAGEFAULT,
   output logic [63:0] oR1_DATA,
   output logic        oMEM_REQ,
   input  logic        iMEM_LOCK,
   output logic [1:0]  oMEM_ORDER,
   output logic        oMEM_RW,
   output logic [31:0] oMEM_ADDR,
   output logic [31:0] oMEM_DATA,
   input  logic        iMEM_VALID,
   input  logic        iMEM_PAGEFAULT,
   input  logic [63:0] iMEM_DATA
);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_BUSY  = 2'd1;
   localparam logic [1:0] c_DRAIN = 2'd2;

   localparam logic [P_CNT_W-1:0] c_MAX_BEATS = P_CNT_W'(P_BURST_BEATS);
   localparam logic [P_CNT_W-1:0] c_ONE       = P_CNT_W'(1);

   logic [1:0]         state_q,  state_d;
   logic               owner_q,  owner_d;
   logic               last_q,   last_d;
   logic [P_CNT_W-1:0] issued_q, issued_d;
   logic [P_CNT_W-1:0] recvd_q,  recvd_d;
   logic [P_CNT_W-1:0] beats_q,  beats_d;

   logic               grant_sel;
   logic [P_CNT_W-1:0] raw_beats;
   logic [P_CNT_W-1:0] clamped_beats;
   logic               own_req;
   logic               busy;
   logic               room;
   logic               accept;
   logic               own_lock;
   logic               fwd;
   logic [P_CNT_W-1:0] recvd_next;

   // On contention the requester that was not served last wins.
   assign grant_sel = iR1_REQ && (!iR0_REQ || !last_q);
   assign raw_beats = grant_sel ? P_CNT_W'(iR1_BEATS) : P_CNT_W'(iR0_BEATS);
   assign clamped_beats = (raw_beats == '0)          ? c_ONE :
                          (raw_beats > c_MAX_BEATS)  ? c_MAX_BEATS : raw_beats;

   assign own_req  = owner_q ? iR1_REQ : iR0_REQ;
   assign busy     = (state_q == c_BUSY);
   assign room     = (issued_q < beats_q);
   assign oMEM_REQ = busy && own_req && room && !iREMOVE;
   assign accept   = oMEM_REQ && !iMEM_LOCK;
   assign own_lock = !busy || iMEM_LOCK || !room || iREMOVE;

   assign oR0_LOCK = owner_q ? 1'b1 : own_lock;
   assign oR1_LOCK = owner_q ? own_lock : 1'b1;

   assign oMEM_ORDER = owner_q ? iR1_ORDER : iR0_ORDER;
   assign oMEM_RW    = owner_q ? iR1_RW    : iR0_RW;
   assign oMEM_ADDR  = owner_q ? iR1_ADDR  : iR0_ADDR;
   assign oMEM_DATA  = owner_q ? iR1_DATA  : iR0_DATA;

   // Responses are forwarded only while a burst is live; in DRAIN they are dropped.
   assign fwd           = busy && iMEM_VALID;
   assign oR0_VALID     = fwd && !owner_q;
   assign oR1_VALID     = fwd && owner_q;
   assign oR0_PAGEFAULT = oR0_VALID && iMEM_PAGEFAULT;
   assign oR1_PAGEFAULT = oR1_VALID && iMEM_PAGEFAULT;
   assign oR0_DATA      = iMEM_DATA;
   assign oR1_DATA      = iMEM_DATA;

   assign recvd_next = recvd_q + P_CNT_W'(iMEM_VALID);

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      last_d   = last_q;
      issued_d = issued_q;
      recvd_d  = recvd_q;
      beats_d  = beats_q;
      case (state_q)
         c_IDLE: begin
            if (!iREMOVE && (iR0_REQ || iR1_REQ)) begin
               state_d  = c_BUSY;
               owner_d  = grant_sel;
               beats_d  = clamped_beats;
               issued_d = '0;
               recvd_d  = '0;
            end
         end
         c_BUSY: begin
            issued_d = issued_q + P_CNT_W'(accept);
            recvd_d  = recvd_next;
            if (recvd_next >= beats_q) begin
               state_d = c_IDLE;
               last_d  = owner_q;
            end else if (iREMOVE) begin
               state_d = c_DRAIN;
            end
         end
         c_DRAIN: begin
            recvd_d = recvd_next;
            if (recvd_next >= issued_q) begin
               state_d = c_IDLE;
            end
         end
         default: state_d = c_IDLE;
      endcase
   end

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         state_q  <= c_IDLE;
         owner_q  <= 1'b0;
         last_q   <= 1'b1;
         issued_q <= '0;
         recvd_q  <= '0;
         beats_q  <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         last_q   <= last_d;
         issued_q <= issued_d;
         recvd_q  <= recvd_d;
         beats_q  <= beats_d;
      end
   end

endmodule
`default_nettype wire
